// File: rtl/phase_sequencer.sv
// phase_sequencer
// ---------------------------------------------------------------------------
// Automatic phase scheduler for the two-direction traffic/pedestrian crossing.
// A prescaler divides the system clock into one-second ticks. Each phase is
// held for a programmed number of seconds, then the fixed ring A..F advances.
// Pedestrian requests are latched and served on entry to the matching walk
// phase. A manual mode freezes the timer so phases advance only on step edges.
//
// Parameters
//   TICK_DIV  clock cycles per one-second tick (2 .. 2^32-1)
//   GREEN_S   seconds in phases A and D (steady walk, 1..99)
//   FLASH_S   seconds in phases B and E (flashing don't-walk, 1..99)
//   YELLOW_S  seconds in phases C and F (1..99)
//
// Ports
//   clock      system clock
//   resetn     synchronous active-low reset
//   ped_req1   direction-1 pedestrian button (level, any high cycle latches)
//   ped_req2   direction-2 pedestrian button
//   manual     1 = timer frozen, phases advance only on step
//   step       manual advance switch, only its rising edge acts
//   state      4-bit phase code, A=0 .. F=5
//   walk1      P1 may show walk/flash during D and E
//   walk2      P2 may show walk/flash during A and B
//   pending1   direction-1 request latched but not yet served
//   pending2   direction-2 request latched but not yet served
//   secs_left  binary seconds remaining in the current phase
//   secs_bcd   secs_left as two BCD digits (combinational)
//   tick       one-cycle pulse at each second boundary
// ---------------------------------------------------------------------------
module phase_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_S  = 10,
  parameter int unsigned FLASH_S  = 5,
  parameter int unsigned YELLOW_S = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ped_req1,
  input  logic       ped_req2,
  input  logic       manual,
  input  logic       step,
  output logic [3:0] state,
  output logic       walk1,
  output logic       walk2,
  output logic       pending1,
  output logic       pending2,
  output logic [7:0] secs_left,
  output logic [7:0] secs_bcd,
  output logic       tick
);

  typedef enum logic [3:0] {
    StA = 4'd0,
    StB = 4'd1,
    StC = 4'd2,
    StD = 4'd3,
    StE = 4'd4,
    StF = 4'd5
  } phase_e;

  localparam logic [31:0] TickMax    = 32'(TICK_DIV - 1);
  localparam logic [7:0]  GreenSecs  = 8'(GREEN_S);
  localparam logic [7:0]  FlashSecs  = 8'(FLASH_S);
  localparam logic [7:0]  YellowSecs = 8'(YELLOW_S);

  phase_e      state_q, state_d, next_phase;
  logic [7:0]  secs_q, secs_d;
  logic        walk1_q, walk1_d;
  logic        walk2_q, walk2_d;
  logic        pending1_q, pending1_d;
  logic        pending2_q, pending2_d;
  logic [31:0] prescaler_q, prescaler_d;
  logic        tick_q, tick_d;
  logic        step_q;
  logic        manual_q;
  logic        step_edge;
  logic        manual_fall;
  logic        state_valid;
  logic        advance;
  logic [7:0]  bcd;

  // Duration of a phase in seconds.
  function automatic logic [7:0] phase_secs(phase_e ph);
    case (ph)
      StA, StD: phase_secs = GreenSecs;
      StB, StE: phase_secs = FlashSecs;
      default:  phase_secs = YellowSecs;
    endcase
  endfunction

  assign step_edge   = step & ~step_q;
  assign manual_fall = manual_q & ~manual;
  assign state_valid = (state_q <= StF);

  // Fixed ring A->B->C->D->E->F->A; unreachable codes recover to A.
  always_comb begin
    case (state_q)
      StA:     next_phase = StB;
      StB:     next_phase = StC;
      StC:     next_phase = StD;
      StD:     next_phase = StE;
      StE:     next_phase = StF;
      default: next_phase = StA;
    endcase
  end

  // Prescaler. Held at zero in manual mode so that leaving manual starts a
  // fresh full second. tick is registered: it is set for the cycle in which
  // the prescaler sits at its terminal count.
  always_comb begin
    if (manual) begin
      prescaler_d = '0;
    end else if (prescaler_q == TickMax) begin
      prescaler_d = '0;
    end else begin
      prescaler_d = prescaler_q + 32'd1;
    end
    tick_d = ~manual & (prescaler_d == TickMax);
  end

  // Phase, countdown and request latches.
  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    walk1_d    = walk1_q;
    walk2_d    = walk2_q;
    pending1_d = pending1_q | ped_req1;
    pending2_d = pending2_q | ped_req2;
    advance    = 1'b0;

    // manual is checked before the tick so a manual rise on an expiring tick
    // freezes the phase instead of advancing it.
    if (!state_valid) begin
      advance = 1'b1;
    end else if (manual) begin
      advance = step_edge;
    end else begin
      advance = tick_q & (secs_q == 8'd1);
    end

    if (advance) begin
      state_d = next_phase;
      secs_d  = phase_secs(next_phase);
      // A request arriving in the entry cycle is served directly, so the
      // pending flag never sees it.
      case (next_phase)
        StA: begin
          walk2_d    = pending2_q | ped_req2;
          pending2_d = 1'b0;
        end
        StC: walk2_d = 1'b0;
        StD: begin
          walk1_d    = pending1_q | ped_req1;
          pending1_d = 1'b0;
        end
        StF: walk1_d = 1'b0;
        default: ;
      endcase
    end else if (manual_fall) begin
      secs_d = phase_secs(state_q);
    end else if (!manual && tick_q && (secs_q > 8'd1)) begin
      secs_d = secs_q - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StA;
      secs_q      <= GreenSecs;
      walk1_q     <= 1'b0;
      walk2_q     <= 1'b0;
      pending1_q  <= 1'b0;
      pending2_q  <= 1'b0;
      prescaler_q <= '0;
      tick_q      <= 1'b0;
      step_q      <= 1'b0;
      manual_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      secs_q      <= secs_d;
      walk1_q     <= walk1_d;
      walk2_q     <= walk2_d;
      pending1_q  <= pending1_d;
      pending2_q  <= pending2_d;
      prescaler_q <= prescaler_d;
      tick_q      <= tick_d;
      step_q      <= step;
      manual_q    <= manual;
    end
  end

  // Shift-and-add-3 binary to BCD. Only the units digit needs correcting:
  // for inputs up to 99 the tens digit stays below 5 before the final shift.
  always_comb begin
    bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0] > 4'd4) bcd[3:0] = bcd[3:0] + 4'd3;
      bcd = {bcd[6:0], secs_q[i]};
    end
  end

  assign state     = state_q;
  assign walk1     = walk1_q;
  assign walk2     = walk2_q;
  assign pending1  = pending1_q;
  assign pending2  = pending2_q;
  assign secs_left = secs_q;
  assign secs_bcd  = bcd;
  assign tick      = tick_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Testbench for phase_sequencer: directed scenarios plus a randomized run
// checked against a seconds/elapsed-time reference model.
module tb_phase_sequencer;

  localparam int TD = 4;
  localparam int GS = 3;
  localparam int FS = 2;
  localparam int YS = 1;

  logic       clock = 1'b0;
  logic       rstn  = 1'b0;
  logic       req1  = 1'b0;
  logic       req2  = 1'b0;
  logic       man   = 1'b0;
  logic       stp   = 1'b0;
  logic [3:0] state;
  logic       walk1, walk2, pend1, pend2, tick;
  logic [7:0] secs, bcd;

  logic       rstn_b = 1'b0;
  logic [3:0] state_b;
  logic       walk1_b, walk2_b, pend1_b, pend2_b, tick_b;
  logic [7:0] secs_b, bcd_b;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: phase index, seconds at start of the running segment,
  // cycles elapsed in that segment (tracks the prescaler), request flags.
  int m_phase = 0;
  int m_base  = GS;
  int m_el    = 0;
  bit m_p1 = 0, m_p2 = 0, m_w1 = 0, m_w2 = 0;
  bit m_step_prev = 0, m_man_prev = 0;

  always #5 clock = ~clock;

  phase_sequencer #(
    .TICK_DIV(TD),
    .GREEN_S (GS),
    .FLASH_S (FS),
    .YELLOW_S(YS)
  ) u_dut (
    .clock    (clock),
    .resetn   (rstn),
    .ped_req1 (req1),
    .ped_req2 (req2),
    .manual   (man),
    .step     (stp),
    .state    (state),
    .walk1    (walk1),
    .walk2    (walk2),
    .pending1 (pend1),
    .pending2 (pend2),
    .secs_left(secs),
    .secs_bcd (bcd),
    .tick     (tick)
  );

  phase_sequencer #(
    .TICK_DIV(2),
    .GREEN_S (99),
    .FLASH_S (5),
    .YELLOW_S(3)
  ) u_bcd (
    .clock    (clock),
    .resetn   (rstn_b),
    .ped_req1 (1'b0),
    .ped_req2 (1'b0),
    .manual   (1'b0),
    .step     (1'b0),
    .state    (state_b),
    .walk1    (walk1_b),
    .walk2    (walk2_b),
    .pending1 (pend1_b),
    .pending2 (pend2_b),
    .secs_left(secs_b),
    .secs_bcd (bcd_b),
    .tick     (tick_b)
  );

  function automatic int dur(int ph);
    case (ph)
      0, 3:    return GS;
      1, 4:    return FS;
      default: return YS;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  // Advance the model across one clock edge using the inputs sampled there.
  task automatic model_update();
    int secs_now;
    bit tick_now, adv, old_p1, old_p2;
    if (!rstn) begin
      m_phase = 0; m_base = GS; m_el = 0;
      m_p1 = 0; m_p2 = 0; m_w1 = 0; m_w2 = 0;
      m_step_prev = 0; m_man_prev = 0;
      return;
    end
    secs_now = m_base - m_el / TD;
    tick_now = (m_el % TD) == TD - 1;
    adv      = man ? (stp && !m_step_prev) : (tick_now && secs_now == 1);
    old_p1   = m_p1;
    old_p2   = m_p2;
    m_p1     = m_p1 | req1;
    m_p2     = m_p2 | req2;
    if (adv) begin
      m_phase = (m_phase + 1) % 6;
      m_base  = dur(m_phase);
      m_el    = 0;
      if (m_phase == 0) begin m_w2 = old_p2 | req2; m_p2 = 0; end
      if (m_phase == 2) m_w2 = 0;
      if (m_phase == 3) begin m_w1 = old_p1 | req1; m_p1 = 0; end
      if (m_phase == 5) m_w1 = 0;
    end else if (man) begin
      m_base = secs_now;
      m_el   = 0;
    end else if (m_man_prev) begin
      m_base = dur(m_phase);
      m_el   = 1;
    end else begin
      m_el++;
    end
    m_step_prev = stp;
    m_man_prev  = man;
  endtask

  task automatic step_cycle();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step_cycle();
    rstn = 1'b1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim, output bit ok);
    int n = 0;
    while (state !== s && n < lim) begin
      step_cycle();
      n++;
    end
    ok = (state === s);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req1 = 1'b1;
    step_cycle();
    step_cycle();
    n_checks++;
    if (state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state);
    else n_pass++;
    n_checks++;
    if (secs !== 8'(GS)) $display("FAIL reset_secs got=%0d exp=%0d", secs, GS);
    else n_pass++;
    n_checks++;
    if ({walk1, walk2, pend1, pend2} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {walk1, walk2, pend1, pend2});
    else n_pass++;
    n_checks++;
    if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick);
    else n_pass++;
    n_checks++;
    if (bcd !== 8'h03) $display("FAIL reset_bcd got=%h exp=03", bcd);
    else n_pass++;
    req1 = 1'b0;
    rstn = 1'b1;
  endtask

  // Free-running sequence straight out of reset, no requests.
  task automatic test_timing();
    int dw[6];
    int off, ph, es;
    logic et;
    for (int p = 0; p < 6; p++) dw[p] = dur(p) * TD;
    for (int c = 1; c <= 49; c++) begin
      off = (c - 1) % 48;
      ph  = 0;
      while (off >= dw[ph]) begin
        off -= dw[ph];
        ph++;
      end
      es = dur(ph) - off / TD;
      et = (c % TD) == 0;
      n_checks++;
      if (state !== 4'(ph)) $display("FAIL timing_state c=%0d got=%0d exp=%0d", c, state, ph);
      else n_pass++;
      n_checks++;
      if (secs !== 8'(es)) $display("FAIL timing_secs c=%0d got=%0d exp=%0d", c, secs, es);
      else n_pass++;
      n_checks++;
      if (tick !== et) $display("FAIL timing_tick c=%0d got=%b exp=%b", c, tick, et);
      else n_pass++;
      n_checks++;
      if ({walk1, walk2} !== 2'b00) $display("FAIL timing_walk c=%0d got=%b exp=00", c,
                                             {walk1, walk2});
      else n_pass++;
      if (c < 49) step_cycle();
    end
  endtask

  task automatic test_request();
    bit ok, held;
    do_reset();
    req1 = 1'b1;
    step_cycle();
    req1 = 1'b0;
    n_checks++;
    if (pend1 !== 1'b1) $display("FAIL req_pending_set got=%b exp=1", pend1);
    else n_pass++;
    wait_state(4'd3, 100, ok);
    n_checks++;
    if (!ok) $display("FAIL req_reach_d got=%0d exp=3", state);
    else n_pass++;
    n_checks++;
    if ({walk1, pend1, walk2} !== 3'b100)
      $display("FAIL req_d_entry got=%b exp=100", {walk1, pend1, walk2});
    else n_pass++;
    held = 1;
    while (state !== 4'd5 && (state === 4'd3 || state === 4'd4)) begin
      if (walk1 !== 1'b1) held = 0;
      step_cycle();
    end
    n_checks++;
    if (held !== 1'b1) $display("FAIL req_walk_held got=%b exp=1", held);
    else n_pass++;
    n_checks++;
    if ({state, walk1} !== {4'd5, 1'b0})
      $display("FAIL req_f_entry got=%0d/%b exp=5/0", state, walk1);
    else n_pass++;
  endtask

  task automatic test_served_press();
    bit ok;
    do_reset();
    req2 = 1'b1;
    step_cycle();
    req2 = 1'b0;
    wait_state(4'd1, 100, ok);
    wait_state(4'd0, 100, ok);
    n_checks++;
    if ({ok, walk2, pend2} !== 3'b110)
      $display("FAIL served_a_entry got=%b exp=110", {ok, walk2, pend2});
    else n_pass++;
    wait_state(4'd1, 100, ok);
    req2 = 1'b1;
    step_cycle();
    req2 = 1'b0;
    n_checks++;
    if ({ok, walk2, pend2} !== 3'b111)
      $display("FAIL served_b_press got=%b exp=111", {ok, walk2, pend2});
    else n_pass++;
    wait_state(4'd2, 100, ok);
    n_checks++;
    if ({ok, walk2, pend2} !== 3'b101)
      $display("FAIL served_c_entry got=%b exp=101", {ok, walk2, pend2});
    else n_pass++;
    wait_state(4'd0, 100, ok);
    n_checks++;
    if ({ok, walk2, pend2} !== 3'b110)
      $display("FAIL served_next_a got=%b exp=110", {ok, walk2, pend2});
    else n_pass++;
  endtask

  task automatic test_manual();
    int n, cnt;
    bit stable;
    do_reset();
    n = 0;
    while (!(state === 4'd3 && secs === 8'd2) && n < 200) begin
      step_cycle();
      n++;
    end
    n_checks++;
    if (n >= 200) $display("FAIL man_reach_d got=%0d/%0d exp=3/2", state, secs);
    else n_pass++;
    man    = 1'b1;
    stable = 1;
    repeat (40) begin
      step_cycle();
      if (state !== 4'd3 || secs !== 8'd2 || tick !== 1'b0) stable = 0;
    end
    n_checks++;
    if (stable !== 1'b1) $display("FAIL man_frozen got=%0d/%0d exp=3/2", state, secs);
    else n_pass++;
    stp = 1'b1;
    step_cycle();
    n_checks++;
    if ({state, secs} !== {4'd4, 8'(FS)})
      $display("FAIL man_step got=%0d/%0d exp=4/%0d", state, secs, FS);
    else n_pass++;
    repeat (5) step_cycle();
    n_checks++;
    if (state !== 4'd4) $display("FAIL man_step_held got=%0d exp=4", state);
    else n_pass++;
    stp = 1'b0;
    step_cycle();
    man = 1'b0;
    cnt = 1;
    step_cycle();
    n_checks++;
    if (secs !== 8'(FS)) $display("FAIL man_release_secs got=%0d exp=%0d", secs, FS);
    else n_pass++;
    while (state === 4'd4 && cnt < 40) begin
      cnt++;
      step_cycle();
    end
    n_checks++;
    if (cnt != FS * TD || state !== 4'd5)
      $display("FAIL man_release_dwell got=%0d exp=%0d", cnt, FS * TD);
    else n_pass++;
    stp = 1'b1;
    step_cycle();
    n_checks++;
    if (state !== 4'd5) $display("FAIL auto_step_ignored got=%0d exp=5", state);
    else n_pass++;
    stp = 1'b0;
  endtask

  task automatic test_bcd();
    int s;
    rstn_b = 1'b0;
    step_cycle();
    step_cycle();
    n_checks++;
    if ({secs_b, bcd_b} !== {8'd99, 8'h99})
      $display("FAIL bcd_reset got=%0d/%h exp=99/99", secs_b, bcd_b);
    else n_pass++;
    rstn_b = 1'b1;
    for (int c = 1; c <= 198; c++) begin
      s = 99 - (c - 1) / 2;
      n_checks++;
      if (bcd_b !== to_bcd(s)) $display("FAIL bcd_value c=%0d got=%h exp=%h", c, bcd_b, to_bcd(s));
      else n_pass++;
      n_checks++;
      if (state_b !== 4'd0 || tick_b !== 1'((c % 2) == 0))
        $display("FAIL bcd_state_tick c=%0d got=%0d/%b", c, state_b, tick_b);
      else n_pass++;
      step_cycle();
    end
    n_checks++;
    if ({state_b, secs_b} !== {4'd1, 8'd5})
      $display("FAIL bcd_to_b got=%0d/%0d exp=1/5", state_b, secs_b);
    else n_pass++;
    n_checks++;
    if ({walk1_b, walk2_b, pend1_b, pend2_b} !== 4'b0000)
      $display("FAIL bcd_flags got=%b exp=0000", {walk1_b, walk2_b, pend1_b, pend2_b});
    else n_pass++;
  endtask

  task automatic test_midreset();
    bit ok;
    do_reset();
    req1 = 1'b1;
    step_cycle();
    req1 = 1'b0;
    wait_state(4'd4, 100, ok);
    req2 = 1'b1;
    step_cycle();
    req2 = 1'b0;
    n_checks++;
    if ({ok, state, walk1, pend2} !== {1'b1, 4'd4, 1'b1, 1'b1})
      $display("FAIL midreset_setup got=%0d/%b/%b exp=4/1/1", state, walk1, pend2);
    else n_pass++;
    rstn = 1'b0;
    step_cycle();
    rstn = 1'b1;
    n_checks++;
    if ({state, secs} !== {4'd0, 8'(GS)})
      $display("FAIL midreset_state got=%0d/%0d exp=0/%0d", state, secs, GS);
    else n_pass++;
    n_checks++;
    if ({pend1, pend2, walk1, walk2} !== 4'b0000)
      $display("FAIL midreset_flags got=%b exp=0000", {pend1, pend2, walk1, walk2});
    else n_pass++;
  endtask

  task automatic test_random();
    int es;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req1 = ($urandom_range(0, 15) == 0);
      req2 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) man = ~man;
      if ($urandom_range(0, 3) == 0) stp = ~stp;
      rstn = ($urandom_range(0, 799) != 0);
      step_cycle();
      es = m_base - m_el / TD;
      n_checks++;
      if (state !== 4'(m_phase)) $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, state, m_phase);
      else n_pass++;
      n_checks++;
      if (secs !== 8'(es)) $display("FAIL rnd_secs i=%0d got=%0d exp=%0d", i, secs, es);
      else n_pass++;
      n_checks++;
      if (bcd !== to_bcd(es)) $display("FAIL rnd_bcd i=%0d got=%h exp=%h", i, bcd, to_bcd(es));
      else n_pass++;
      n_checks++;
      if ({walk1, walk2} !== {m_w1, m_w2})
        $display("FAIL rnd_walk i=%0d got=%b exp=%b", i, {walk1, walk2}, {m_w1, m_w2});
      else n_pass++;
      n_checks++;
      if ({pend1, pend2} !== {m_p1, m_p2})
        $display("FAIL rnd_pending i=%0d got=%b exp=%b", i, {pend1, pend2}, {m_p1, m_p2});
      else n_pass++;
      n_checks++;
      if (tick !== 1'((m_el % TD) == TD - 1))
        $display("FAIL rnd_tick i=%0d got=%b exp=%b", i, tick, (m_el % TD) == TD - 1);
      else n_pass++;
    end
    req1 = 1'b0;
    req2 = 1'b0;
    man  = 1'b0;
    stp  = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_request();
    test_served_press();
    test_manual();
    test_bcd();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
